// File: rtl/game_timer.sv
// Two-digit BCD countdown timer: loads from config switches, decrements once per
// TICKS_PER_SEC enabled cycles, and holds timeout once the count reaches 00.
module game_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int DEFAULT_TENS  = 3,
  parameter int DEFAULT_ONES  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reconfig,
  input  logic       enable,
  input  logic [3:0] cfg_tens,
  input  logic [3:0] cfg_ones,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       sec_tick,
  output logic       timeout
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] RST_TENS = (DEFAULT_TENS > 9) ? 4'd9 : 4'(DEFAULT_TENS);
  localparam logic [3:0] RST_ONES = (DEFAULT_ONES > 9) ? 4'd9 : 4'(DEFAULT_ONES);

  typedef enum logic [1:0] {LOADED, COUNTING, PAUSED, EXPIRED} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    ones_reg, ones_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          tick_reg, tick_next;
  logic          timeout_reg, timeout_next;
  logic          advance;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= LOADED;
      tens_reg    <= RST_TENS;
      ones_reg    <= RST_ONES;
      presc_reg   <= '0;
      tick_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tens_reg    <= tens_next;
      ones_reg    <= ones_next;
      presc_reg   <= presc_next;
      tick_reg    <= tick_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tens_next    = tens_reg;
    ones_next    = ones_reg;
    presc_next   = presc_reg;
    tick_next    = 1'b0;
    timeout_next = timeout_reg;
    advance      = 1'b0;

    if (reconfig) begin
      state_next   = LOADED;
      tens_next    = clamp_digit(cfg_tens);
      ones_next    = clamp_digit(cfg_ones);
      presc_next   = '0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        LOADED, PAUSED: begin
          if (enable) begin
            // A zero count expires on the first enabled cycle without a tick.
            if (tens_reg == 4'd0 && ones_reg == 4'd0) begin
              state_next   = EXPIRED;
              timeout_next = 1'b1;
              presc_next   = '0;
            end else begin
              state_next = COUNTING;
              advance    = 1'b1;
            end
          end
        end
        COUNTING: begin
          if (enable) advance = 1'b1;
          else        state_next = PAUSED;
        end
        EXPIRED: presc_next = '0;
      endcase

      if (advance) begin
        if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          tick_next  = 1'b1;
          if (ones_reg != 4'd0) begin
            ones_next = ones_reg - 4'd1;
          end else begin
            ones_next = 4'd9;
            tens_next = tens_reg - 4'd1;
          end
          if (tens_reg == 4'd0 && ones_reg == 4'd1) begin
            state_next   = EXPIRED;
            timeout_next = 1'b1;
          end
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
    end
  end

  assign secs_tens = tens_reg;
  assign secs_ones = ones_reg;
  assign sec_tick  = tick_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios plus randomized traffic,
// all compared against an integer-seconds reference model.
module tb_game_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reconfig = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] cfg_tens = 4'd0;
  logic [3:0] cfg_ones = 4'd0;
  logic [3:0] secs_tens, secs_ones;
  logic       sec_tick, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining seconds as an integer, enabled cycles into the current second.
  int   m_secs  = 30;
  int   m_phase = 0;
  bit   m_exp   = 1'b0;
  bit   m_tick  = 1'b0;
  logic [9:0] m_out;
  logic [9:0] dut_out;

  game_timer #(.TICKS_PER_SEC(TPS), .DEFAULT_TENS(3), .DEFAULT_ONES(0)) dut (
    .clk(clk), .reset(reset), .reconfig(reconfig), .enable(enable),
    .cfg_tens(cfg_tens), .cfg_ones(cfg_ones),
    .secs_tens(secs_tens), .secs_ones(secs_ones),
    .sec_tick(sec_tick), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign dut_out = {secs_tens, secs_ones, sec_tick, timeout};

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_refresh();
    m_out = {4'(m_secs / 10), 4'(m_secs % 10), m_tick, m_exp};
  endtask

  task automatic model_reset();
    m_secs = 30; m_phase = 0; m_exp = 1'b0; m_tick = 1'b0;
    model_refresh();
  endtask

  task automatic model_step(input logic rc, input logic en, input logic [3:0] ct, input logic [3:0] co);
    m_tick = 1'b0;
    if (rc) begin
      m_secs = clampd(ct) * 10 + clampd(co);
      m_phase = 0;
      m_exp = 1'b0;
    end else if (!m_exp && en) begin
      if (m_secs == 0) begin
        m_exp = 1'b1;
      end else begin
        m_phase++;
        if (m_phase == TPS) begin
          m_phase = 0;
          m_secs--;
          m_tick = 1'b1;
          if (m_secs == 0) m_exp = 1'b1;
        end
      end
    end
    model_refresh();
  endtask

  // Drive one clock cycle of inputs, advance the model at the edge, settle before sampling.
  task automatic cycle(input logic rc, input logic en, input logic [3:0] ct, input logic [3:0] co);
    @(negedge clk);
    reconfig = rc; enable = en; cfg_tens = ct; cfg_ones = co;
    @(posedge clk);
    model_step(rc, en, ct, co);
    #1;
    if (rc) $display("load cfg %h/%h at %0t", ct, co, $time);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12 reset = 1'b1;
    cycle(1'b1, 1'b0, 4'd1, 4'd2);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_out !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_async got %h want %h", dut_out, {4'd3, 4'd0, 1'b0, 1'b0});
    end
    #3 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 4'd0);
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL reset_idle[%0d] got %h want %h", i, dut_out, m_out);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_load_count();
    int ticks = 0;
    cycle(1'b1, 1'b0, 4'd1, 4'd2);
    n_cmp++;
    if (dut_out !== {4'd1, 4'd2, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL load_12 got %h want %h", dut_out, {4'd1, 4'd2, 1'b0, 1'b0});
    end
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b1, 4'd0, 4'd0);
      if (sec_tick) ticks++;
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL count_model[%0d] got %h want %h", i, dut_out, m_out);
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (dut_out !== ((i == 3) ? {4'd1, 4'd2, 1'b0, 1'b0} : {4'd1, 4'd1, 1'b1, 1'b0})) begin
          n_bad++; $display("FAIL first_decrement[%0d] got %h", i, dut_out);
        end
      end
    end
    n_cmp++;
    if ({secs_tens, secs_ones} !== 8'h09 || ticks != 3) begin
      n_bad++; $display("FAIL count_to_09 got %h ticks %0d want 09 ticks 3", {secs_tens, secs_ones}, ticks);
    end
    $display("test_load_count done");
  endtask

  task automatic test_expiry();
    cycle(1'b1, 1'b0, 4'd0, 4'd2);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 4'd0, 4'd0);
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL expiry_model[%0d] got %h want %h", i, dut_out, m_out);
      end
    end
    n_cmp++;
    if (dut_out !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL expiry_edge got %h want %h", dut_out, {4'd0, 4'd0, 1'b1, 1'b1});
    end
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, (i < 20), 4'd0, 4'd0);
      n_cmp++;
      if (dut_out !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
        n_bad++; $display("FAIL expired_hold[%0d] got %h want %h", i, dut_out, {4'd0, 4'd0, 1'b0, 1'b1});
      end
    end
    $display("test_expiry done");
  endtask

  task automatic test_pause();
    cycle(1'b1, 1'b0, 4'd0, 4'd5);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, (i < 3 || i == 13), 4'd0, 4'd0);
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL pause_model[%0d] got %h want %h", i, dut_out, m_out);
      end
      if (i >= 12) begin
        n_cmp++;
        if (dut_out !== ((i == 12) ? {4'd0, 4'd5, 1'b0, 1'b0} : {4'd0, 4'd4, 1'b1, 1'b0})) begin
          n_bad++; $display("FAIL pause_resume[%0d] got %h", i, dut_out);
        end
      end
    end
    $display("test_pause done");
  endtask

  task automatic test_collisions();
    cycle(1'b1, 1'b0, 4'd0, 4'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd0, 4'd3);
    n_cmp++;
    if (dut_out !== {4'd0, 4'd3, 1'b0, 1'b0} || dut_out !== m_out) begin
      n_bad++; $display("FAIL reload_on_final got %h want %h", dut_out, {4'd0, 4'd3, 1'b0, 1'b0});
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 4'd0, 4'd0);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++; $display("FAIL collide_expire got %b want 1", timeout);
    end
    cycle(1'b1, 1'b0, 4'hC, 4'hF);
    n_cmp++;
    if (dut_out !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL clamp_reload got %h want %h", dut_out, {4'd9, 4'd9, 1'b0, 1'b0});
    end
    $display("test_collisions done");
  endtask

  task automatic test_zero_and_reset();
    cycle(1'b1, 1'b0, 4'd0, 4'd0);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++; $display("FAIL zero_load got timeout %b want 0", timeout);
    end
    cycle(1'b0, 1'b1, 4'd0, 4'd0);
    n_cmp++;
    if (dut_out !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL zero_expire got %h want %h", dut_out, {4'd0, 4'd0, 1'b0, 1'b1});
    end
    cycle(1'b1, 1'b0, 4'd2, 4'd0);
    cycle(1'b0, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    enable = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 4'd0, 4'd0);
      n_cmp++;
      if (dut_out !== ((i < 4) ? {4'd3, 4'd0, 1'b0, 1'b0} : {4'd2, 4'd9, 1'b1, 1'b0})) begin
        n_bad++; $display("FAIL reset_restart[%0d] got %h", i, dut_out);
      end
    end
    $display("test_zero_and_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic rc, en;
      logic [3:0] ct, co;
      rc = ($urandom_range(0, 24) == 0);
      en = ($urandom_range(0, 3) != 0);
      ct = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
      co = 4'($urandom_range(0, 15));
      cycle(rc, en, ct, co);
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL random[%0d] got %h want %h", i, dut_out, m_out);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_expiry();
    test_pause();
    test_collisions();
    test_zero_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game timer for the mental-math challenge. It holds a two-digit BCD seconds value, which is loaded from switches when access control pulses `reconfig`. While `enable` is high it counts down once per second. It raises `timeout` on reaching 00, which access control uses to leave game play and enter scoring. The count outputs drive the seven-segment display path directly.

## Interface
- `TICKS_PER_SEC`, 50000000: clock cycles per second. Must be ≥ 2; benches use 4.
- `DEFAULT_TENS`, 3: tens digit loaded at reset.
- `DEFAULT_ONES`, 0: ones digit loaded at reset.
- `clk` in 1: system clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `reconfig` in 1: one-cycle load strobe from access control.
- `enable` in 1: level input; high means the game is running.
- `cfg_tens` in 4: BCD tens digit of the new duration.
- `cfg_ones` in 4: BCD ones digit of the new duration.
- `secs_tens` out 4: current tens digit, BCD.
- `secs_ones` out 4: current ones digit, BCD.
- `sec_tick` out 1: one-cycle pulse on every decrement.
- `timeout` out 1: level output; high while the count is expired.

## Operation
- Prescaler width is `$clog2(TICKS_PER_SEC)`. It counts 0 … `TICKS_PER_SEC-1`, then wraps to 0.
- States:
  - LOADED: count valid; no enabled cycle seen since the load.
  - COUNTING: `enable` is high.
  - PAUSED: `enable` is low after counting started.
  - EXPIRED: count is 00.
- Transitions, in priority order:
  - `reconfig` = 1 from any state → LOADED. Count ← cfg digits, prescaler ← 0, `timeout` ← 0.
  - LOADED or PAUSED with `enable` = 1 → COUNTING.
  - COUNTING with `enable` = 0 → PAUSED.
  - COUNTING, prescaler = `TICKS_PER_SEC-1`, `enable` = 1 → decrement count and pulse `sec_tick`.
    - If the count was 01, go to EXPIRED and set `timeout`.
  - LOADED or PAUSED with count 00 and `enable` = 1 → EXPIRED, `timeout` ← 1. No decrement, no `sec_tick`.
  - EXPIRED → stays until `reconfig` or reset. Prescaler held at 0; `enable` ignored.
- Prescaler:
  - Advances only in COUNTING with `enable` = 1.
  - Holds its value in PAUSED, so a pause keeps the partial second.
- BCD decrement:
  - Ones > 0: ones − 1.
  - Ones = 0: ones ← 9, tens − 1.
  - The count never goes below 00 and never wraps to 99.
- Config sanitising: any cfg digit > 9 is loaded as 9, so 4'hC loads as 9.
- Simultaneous events:
  - `reconfig` with `enable` in the same cycle: the load wins. No decrement, prescaler ← 0, and counting starts on the next enabled cycle.
  - `reconfig` in the same cycle as the final decrement: the load wins and `timeout` stays 0.
- Reset (`reset` = 0, asynchronous):
  - Count ← `DEFAULT_TENS`/`DEFAULT_ONES`, clamped to 9.
  - Prescaler ← 0, state LOADED.
  - `timeout` ← 0, `sec_tick` ← 0.
  - Applies immediately, including mid-count.

## Timing
- All outputs are registered.
- Reset values:
  - `secs_tens` = `DEFAULT_TENS`, `secs_ones` = `DEFAULT_ONES` (3, 0 with defaults).
  - `sec_tick` = 0, `timeout` = 0.
- `reconfig` sampled high at edge N → new digits visible after edge N, `timeout` low after edge N.
- First decrement comes exactly `TICKS_PER_SEC` enabled cycles after LOADED, counting `enable`-high cycles only.
- `sec_tick` is high for exactly the one cycle after the decrementing edge.
- `timeout`:
  - Rises on the same edge that makes the count 00, with `sec_tick` also high that cycle.
  - Stays high until `reconfig` or reset.
- `timeout` stays high with `enable` low. Access control drops `enable` in scoring; the level must persist there.
- Loaded 00 with `enable` first high at edge N → `timeout` high after edge N.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4.
1. Reset: assert `reset` low asynchronously mid-cycle → immediately 3/0, `timeout` 0, `sec_tick` 0. Release; hold `enable` 0 for 20 cycles → unchanged.
2. Load and count: `reconfig` with cfg 1/2, then `enable` high → 1/1 after the 4th enabled edge with one `sec_tick` pulse. After 8 more edges → 0/9.
3. Expiry: load 0/2, `enable` high for 8 cycles → 0/0 and `timeout` = 1 on the same edge. Further 20 enabled cycles → still 0/0, `timeout` 1, no `sec_tick`.
4. Pause:
   - Load 0/5; `enable` high 3 cycles, low 10, high 1 → 0/4 exactly on that 4th enabled edge.
   - `timeout` stays 0 throughout.
5. Collisions and clamp:
   - `reconfig` (cfg 0/3) on the final decrement edge of 0/1 → 0/3, `timeout` 0.
   - `reconfig` during EXPIRED → `timeout` clears next edge.
   - cfg 4'hC/4'hF → 9/9.
6. Zero load and mid-count reset:
   - Load 0/0, `enable` high → `timeout` 1 after the first edge, with no `sec_tick`.
   - Load 2/0 and count 2 cycles, then pulse `reset` → 3/0, prescaler restarts from 0.
